// File: rtl/fpf_rx_decoder_12_if.sv
// Codeword-in / decoded-result-out bundle for the 12-TSV FPF receive decoder.
// master = codeword source and result consumer, slave = decoder.
interface fpf_rx_decoder_12_if #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 16
);
  logic [11:0]       tsv_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              fpf_err;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output tsv_in, in_valid, out_ready,
    input  in_ready, data_out, fpf_err, out_valid, err_count
  );

  modport slave (
    input  tsv_in, in_valid, out_ready,
    output in_ready, data_out, fpf_err, out_valid, err_count
  );
endinterface

// File: rtl/fpf_rx_decoder_12.sv
// Serial Fibonacci (FNS) decoder for 12-wire FPF codewords, with forbidden-pattern
// detection and a saturating link-health counter of violating codewords.
module fpf_rx_decoder_12 #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 16
) (
  input logic                clock,
  input logic                reset,
  fpf_rx_decoder_12_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic [11:0]       shift_r;
  logic [3:0]        idx_r;
  logic [DATA_W-1:0] acc_r;
  logic              flag_r;
  logic [DATA_W-1:0] data_out_r;
  logic              fpf_err_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  err_count_r;

  function automatic logic [DATA_W-1:0] fib_weight(input logic [3:0] idx);
    logic [DATA_W-1:0] w;
    case (idx)
      4'd0:    w = DATA_W'(8'd1);
      4'd1:    w = DATA_W'(8'd1);
      4'd2:    w = DATA_W'(8'd2);
      4'd3:    w = DATA_W'(8'd3);
      4'd4:    w = DATA_W'(8'd5);
      4'd5:    w = DATA_W'(8'd8);
      4'd6:    w = DATA_W'(8'd13);
      4'd7:    w = DATA_W'(8'd21);
      4'd8:    w = DATA_W'(8'd34);
      4'd9:    w = DATA_W'(8'd55);
      4'd10:   w = DATA_W'(8'd89);
      4'd11:   w = DATA_W'(8'd144);
      default: w = '0;
    endcase
    return w;
  endfunction

  // An isolated 1 or 0 between two opposite neighbours is the crosstalk worst case.
  function automatic logic fpf_violation(input logic [11:0] word);
    logic v;
    v = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if ((word[j +: 3] == 3'b010) || (word[j +: 3] == 3'b101)) begin
        v = 1'b1;
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  assign bus.in_ready  = (state_r == IDLE) && !reset;
  assign bus.data_out  = data_out_r;
  assign bus.fpf_err   = fpf_err_r;
  assign bus.out_valid = out_valid_r;
  assign bus.err_count = err_count_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; DONE only releases once the result has actually been handed over.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) next_state_s = ACCUM;
        else              next_state_s = IDLE;
      end
      ACCUM: begin
        if (idx_r == 4'd11) next_state_s = DONE;
        else                next_state_s = ACCUM;
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) next_state_s = IDLE;
        else                              next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Capture, serial accumulation, output staging and violation counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r     <= 12'd0;
      idx_r       <= 4'd0;
      acc_r       <= '0;
      flag_r      <= 1'b0;
      data_out_r  <= '0;
      fpf_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      err_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            shift_r <= bus.tsv_in;
            idx_r   <= 4'd0;
            acc_r   <= '0;
            flag_r  <= fpf_violation(bus.tsv_in);
          end
        end
        ACCUM: begin
          if (shift_r[0]) begin
            acc_r <= acc_r + fib_weight(idx_r);
          end
          shift_r <= {1'b0, shift_r[11:1]};
          idx_r   <= idx_r + 4'd1;
          if ((idx_r == 4'd11) && flag_r && (err_count_r != CNT_MAX)) begin
            err_count_r <= err_count_r + CNT_ONE;
          end
        end
        DONE: begin
          // First DONE cycle stages the finished sum; it then holds through any stall.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            data_out_r  <= acc_r;
            fpf_err_r   <= flag_r;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            fpf_err_r   <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpf_rx_decoder_12.sv
// Scoreboard bench for fpf_rx_decoder_12: directed corner cases, backpressure,
// mid-decode reset, random FPF-encoded traffic and counter saturation.
module tb_fpf_rx_decoder_12;

  typedef struct {
    logic [8:0] data;
    logic       err;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic rand_rdy;
  exp_t sb_q[$];

  fpf_rx_decoder_12_if #(.DATA_W(9), .CNT_W(16)) ifm ();
  fpf_rx_decoder_12_if #(.DATA_W(9), .CNT_W(4))  ifs ();

  fpf_rx_decoder_12 #(.DATA_W(9), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifm)
  );

  fpf_rx_decoder_12 #(.DATA_W(9), .CNT_W(4)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (ifs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int decode_ref(input logic [11:0] w);
    int wt[12];
    int s;
    wt = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
    s = 0;
    for (int i = 0; i < 12; i++) if (w[i]) s += wt[i];
    return s;
  endfunction

  function automatic logic fpf_ref(input logic [11:0] w);
    for (int j = 0; j < 10; j++) begin
      if ((w[j] != w[j+1]) && (w[j+1] != w[j+2])) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Scoreboard: every result handshake pops one expectation.
  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset && ifm.out_valid && ifm.out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("data_out", 32'(ifm.data_out), 32'(mon_e.data));
        check_val("fpf_err", 32'(ifm.fpf_err), 32'(mon_e.err));
      end
    end
  end

  always @(posedge clock) begin
    if (rand_rdy) begin
      #1;
      ifm.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [11:0] w, input logic [8:0] ev, input logic ee);
    int n;
    n = 0;
    @(posedge clock); #1;
    ifm.tsv_in   = w;
    ifm.in_valid = 1'b1;
    @(negedge clock);
    while (!ifm.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ifm.in_ready) check_val("accept_timeout", 32'd0, 32'd1);
    else sb_q.push_back('{data: ev, err: ee});
    @(posedge clock); #1;
    ifm.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  logic [11:0] enc_tab[377];
  bit          have[377];

  initial begin
    int lat;
    int n;
    int missing;
    int v;
    int d;
    checks       = 0;
    errors       = 0;
    rand_rdy     = 1'b0;
    reset        = 1'b1;
    ifm.tsv_in   = 12'd0;
    ifm.in_valid = 1'b0;
    ifm.out_ready = 1'b1;
    ifs.tsv_in   = 12'd0;
    ifs.in_valid = 1'b0;
    ifs.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("in_ready_in_reset", 32'(ifm.in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_in_ready", 32'(ifm.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(ifm.out_valid), 32'd0);
    check_val("rst_data_out", 32'(ifm.data_out), 32'd0);
    check_val("rst_fpf_err", 32'(ifm.fpf_err), 32'd0);
    check_val("rst_err_count", 32'(ifm.err_count), 32'd0);

    // All-zero word and accept-to-valid latency.
    send(12'h000, 9'd0, 1'b0);
    lat = 0;
    while (!ifm.out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'd13);
    drain();
    check_val("err_count_zero", 32'(ifm.err_count), 32'd0);

    send(12'hFFF, 9'd376, 1'b0);
    send(12'b000000000111, 9'd4, 1'b0);
    drain();

    send(12'b000000000101, 9'd3, 1'b1);
    drain();
    check_val("err_count_1", 32'(ifm.err_count), 32'd1);
    send(12'b101000000000, 9'd199, 1'b1);
    drain();
    check_val("err_count_2", 32'(ifm.err_count), 32'd2);

    // Backpressure with a competing codeword offered during the stall.
    ifm.out_ready = 1'b0;
    send(12'b000000001111, 9'd7, 1'b0);
    n = 0;
    while (!ifm.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("stall_valid_seen", 32'(ifm.out_valid), 32'd1);
    @(posedge clock); #1;
    ifm.tsv_in   = 12'h000;
    ifm.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_val("stall_out_valid", 32'(ifm.out_valid), 32'd1);
      check_val("stall_data_out", 32'(ifm.data_out), 32'd7);
      check_val("stall_fpf_err", 32'(ifm.fpf_err), 32'd0);
      check_val("stall_in_ready", 32'(ifm.in_ready), 32'd0);
    end
    @(posedge clock); #1;
    ifm.out_ready = 1'b1;
    @(posedge clock); #1;
    ifm.in_valid = 1'b0;
    @(negedge clock);
    check_val("post_hs_in_ready", 32'(ifm.in_ready), 32'd1);
    check_val("post_hs_out_valid", 32'(ifm.out_valid), 32'd0);
    @(negedge clock);
    check_val("no_second_accept", 32'(ifm.in_ready), 32'd1);
    check_val("sb_empty_after_stall", 32'(sb_q.size()), 32'd0);

    // Reset in the sixth ACCUM cycle discards the partial result and the counter.
    send(12'b000000001111, 9'd7, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clock);
    check_val("midrst_out_valid", 32'(ifm.out_valid), 32'd0);
    check_val("midrst_data_out", 32'(ifm.data_out), 32'd0);
    check_val("midrst_err_count", 32'(ifm.err_count), 32'd0);
    check_val("midrst_in_ready", 32'(ifm.in_ready), 32'd1);
    send(12'b000111111000, 9'd84, 1'b0);
    drain();

    // Reference FPF encoder: a pattern-free codeword for every value 0..376.
    for (int c = 0; c < 4096; c++) begin
      if (!fpf_ref(12'(c))) begin
        d = decode_ref(12'(c));
        if (!have[d]) begin
          enc_tab[d] = 12'(c);
          have[d]    = 1'b1;
        end
      end
    end
    missing = 0;
    for (int i = 0; i < 377; i++) if (!have[i]) missing++;
    check_val("enc_coverage", 32'(missing), 32'd0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      v = $urandom_range(0, 376);
      send(enc_tab[v], 9'(v), 1'b0);
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clock); #1;
    ifm.out_ready = 1'b1;
    check_val("rand_err_count", 32'(ifm.err_count), 32'd0);

    // Saturation of a 4-bit counter with 2^4+3 violating words.
    for (int k = 1; k <= 19; k++) begin
      @(posedge clock); #1;
      ifs.tsv_in   = 12'b000000000010;
      ifs.in_valid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!ifs.in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock); #1;
      ifs.in_valid = 1'b0;
      n = 0;
      while (!ifs.out_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
      check_val("sat_data_out", 32'(ifs.data_out), 32'd1);
      check_val("sat_fpf_err", 32'(ifs.fpf_err), 32'd1);
      check_val("sat_err_count", 32'(ifs.err_count), 32'((k > 15) ? 15 : k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
